// File: rtl/uart_cmd_comm.sv
// Host UART endpoint: assembles 3-byte commands from RX (8N1, LSB first)
// and serializes single response bytes on TX.
module uart_cmd_comm #(
  parameter int BAUD_DIV = 868,
  parameter int TMO_CYC  = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [23:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp_data,
  input  logic        send_resp,
  output logic        resp_sent
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam int TW = $clog2(TMO_CYC + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TMO_CYC - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic {TX_IDLE, TX_XMIT} tx_state_e;

  logic          rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_e     rx_state_q;
  logic [CW-1:0] rx_cnt_q;
  logic [2:0]    rx_bit_q;
  logic [7:0]    rx_sh_q;
  logic [1:0]    byte_cnt_q;
  logic [15:0]   stage_q;
  logic [23:0]   cmd_q;
  logic          cmd_rdy_q;
  logic [TW-1:0] tmo_q;
  logic          byte_acc_d;

  tx_state_e     tx_state_q;
  logic [CW-1:0] tx_cnt_q;
  logic [3:0]    tx_bit_q;
  logic [8:0]    tx_sh_q;
  logic          tx_q;
  logic          resp_sent_q;

  // RX is asynchronous: two sync stages plus one more for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= RX;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  assign byte_acc_d = (rx_state_q == RX_STOP) && (rx_cnt_q == BIT_LAST) && rx_s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
    end else begin
      case (rx_state_q)
        RX_IDLE: begin
          rx_cnt_q <= '0;
          if (!rx_s2_q && rx_prev_q) rx_state_q <= RX_START;
        end
        RX_START: begin
          if (rx_cnt_q == HALF_LAST) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= rx_s2_q ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q <= '0;
            rx_bit_q <= rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        default: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q   <= '0;
            rx_state_q <= RX_IDLE;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rx_state_q == RX_DATA && rx_cnt_q == BIT_LAST) rx_sh_q <= {rx_s2_q, rx_sh_q[7:1]};
    if (byte_acc_d && byte_cnt_q == 2'd0) stage_q[15:8] <= rx_sh_q;
    if (byte_acc_d && byte_cnt_q == 2'd1) stage_q[7:0]  <= rx_sh_q;
  end

  // Command assembly; a load on the same cycle as clr_cmd_rdy keeps cmd_rdy set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_q <= '0;
      cmd_q      <= '0;
      cmd_rdy_q  <= 1'b0;
      tmo_q      <= '0;
    end else begin
      if (byte_cnt_q != 2'd0 && rx_state_q == RX_IDLE) begin
        if (tmo_q == TMO_LAST) begin
          tmo_q      <= '0;
          byte_cnt_q <= '0;
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
      end else begin
        tmo_q <= '0;
      end
      if (clr_cmd_rdy) cmd_rdy_q <= 1'b0;
      if (byte_acc_d) begin
        case (byte_cnt_q)
          2'd0: begin
            byte_cnt_q <= 2'd1;
            cmd_rdy_q  <= 1'b0;
          end
          2'd1: byte_cnt_q <= 2'd2;
          default: begin
            cmd_q      <= {stage_q, rx_sh_q};
            cmd_rdy_q  <= 1'b1;
            byte_cnt_q <= 2'd0;
          end
        endcase
      end
    end
  end

  // Transmitter: start bit comes from tx_q directly, shifter holds {stop, data}
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_q        <= 1'b1;
      resp_sent_q <= 1'b0;
    end else begin
      resp_sent_q <= 1'b0;
      case (tx_state_q)
        TX_IDLE: begin
          if (send_resp) begin
            tx_state_q <= TX_XMIT;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_q       <= 1'b0;
          end
        end
        default: begin
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 4'd9) begin
              tx_state_q  <= TX_IDLE;
              tx_q        <= 1'b1;
              resp_sent_q <= 1'b1;
            end else begin
              tx_bit_q <= tx_bit_q + 4'd1;
              tx_q     <= tx_sh_q[0];
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (tx_state_q == TX_IDLE && send_resp) tx_sh_q <= {1'b1, resp_data};
    else if (tx_state_q == TX_XMIT && tx_cnt_q == BIT_LAST) tx_sh_q <= {1'b1, tx_sh_q[8:1]};
  end

  assign TX        = tx_q;
  assign cmd       = cmd_q;
  assign cmd_rdy   = cmd_rdy_q;
  assign resp_sent = resp_sent_q;

endmodule
